// File: rtl/recv_fifo_sched_pkg.sv
// ----------------------------------------------------------------------------
// recv_fifo_sched_pkg
//   Shared definitions for the rx read scheduler: class tags, word widths,
//   FSM state encoding, grant type and the tagged downstream word layout.
// ----------------------------------------------------------------------------
package recv_fifo_sched_pkg;

    localparam int VID_W = 29;   // video FIFO word width
    localparam int AUX_W = 24;   // aux/audio FIFO word width
    localparam int OUT_W = 30;   // tag bit + widest payload
    localparam int CNT_W = 16;   // forwarded-word counters

    localparam logic TAG_VID = 1'b0;
    localparam logic TAG_AUX = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VID  = 2'd1,
        ST_AUX  = 2'd2
    } state_t;

    typedef enum logic {
        GR_VID = 1'b0,
        GR_AUX = 1'b1
    } grant_t;

    // Downstream word: tag in the MSB, payload right-aligned below it.
    typedef struct packed {
        logic             tag;
        logic [VID_W-1:0] payload;
    } out_word_t;

    function automatic out_word_t tag_vid(input logic [VID_W-1:0] w);
        out_word_t o;
        o.tag     = TAG_VID;
        o.payload = w;
        return o;
    endfunction

    // Aux payload is zero-extended so bits [28:24] are always 0.
    function automatic out_word_t tag_aux(input logic [AUX_W-1:0] w);
        out_word_t o;
        o.tag     = TAG_AUX;
        o.payload = {{(VID_W-AUX_W){1'b0}}, w};
        return o;
    endfunction

endpackage

// File: rtl/recv_fifo_sched_rd_tag_stage.sv
// ----------------------------------------------------------------------------
// recv_fifo_sched_rd_tag_stage
//   Two-stage valid/data pipe behind the FIFO read strobes. A read issued in
//   cycle N has its (non-FWFT) FIFO data available in N+1; that data is tagged
//   and registered so the downstream write strobe fires in N+2.
// Ports
//   clk125, sys_rst_n   clock, async active-low reset
//   rd_en               a read is being issued this cycle (either class)
//   sel                 class of that read (TAG_VID / TAG_AUX)
//   vid_dout, aux_dout  FIFO data outputs
//   out_wr_en           downstream write strobe
//   out_data            tagged downstream word; holds when out_wr_en=0
// ----------------------------------------------------------------------------
module recv_fifo_sched_rd_tag_stage
    import recv_fifo_sched_pkg::*;
(
    input  logic             clk125,
    input  logic             sys_rst_n,
    input  logic             rd_en,
    input  logic             sel,
    input  logic [VID_W-1:0] vid_dout,
    input  logic [AUX_W-1:0] aux_dout,
    output logic             out_wr_en,
    output logic [OUT_W-1:0] out_data
);

    localparam int LAT = 2;

    // vld_pipe[0]: FIFO data valid this cycle; vld_pipe[LAT-1]: write strobe
    logic [LAT-1:0] vld_pipe;
    logic           sel_q;
    out_word_t      word_q;

    always_ff @(posedge clk125 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vld_pipe <= '0;
            sel_q    <= TAG_VID;
            word_q   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[LAT-2:0], rd_en};
            if (rd_en)
                sel_q <= sel;
            // Only load on a real capture so out_data holds between writes.
            if (vld_pipe[0])
                word_q <= (sel_q == TAG_AUX) ? tag_aux(aux_dout) : tag_vid(vid_dout);
        end
    end

    assign out_wr_en = vld_pipe[LAT-1];
    assign out_data  = word_q;

endmodule

// File: rtl/recv_fifo_sched.sv
// ----------------------------------------------------------------------------
// recv_fifo_sched
//   Drains the rx video FIFO (29-bit) and aux/audio FIFO (24-bit) into one
//   tagged downstream write port. Round-robin between classes, a video
//   quantum and an aux burst limit bound each grant, and an urgent-aux rule
//   (fill level >= AUX_HI) wins arbitration in IDLE to keep the audio FIFO
//   from overflowing. A grant in progress is never preempted.
// Ports
//   clk125, sys_rst_n        clock, async active-low reset
//   enable                   scheduling allowed
//   vid_empty/vid_dout       video FIFO status/data (data 1 cycle after read)
//   vid_rd_en                video FIFO read strobe
//   aux_empty/aux_dout       aux FIFO status/data
//   aux_count                aux FIFO fill level
//   aux_rd_en                aux FIFO read strobe
//   out_afull                downstream almost-full (>=3 words of slack)
//   out_wr_en/out_data       downstream write port, [29] = class tag
//   vid_words/aux_words      wrapping counts of forwarded words per class
// ----------------------------------------------------------------------------
module recv_fifo_sched
    import recv_fifo_sched_pkg::*;
#(
    parameter int VID_QUANTUM = 16,
    parameter int AUX_BURST   = 4,
    parameter int AUX_CW      = 7,
    parameter int AUX_HI      = 48
)(
    input  logic              clk125,
    input  logic              sys_rst_n,
    input  logic              enable,
    input  logic              vid_empty,
    input  logic [VID_W-1:0]  vid_dout,
    output logic              vid_rd_en,
    input  logic              aux_empty,
    input  logic [AUX_W-1:0]  aux_dout,
    input  logic [AUX_CW-1:0] aux_count,
    output logic              aux_rd_en,
    input  logic              out_afull,
    output logic              out_wr_en,
    output logic [OUT_W-1:0]  out_data,
    output logic [CNT_W-1:0]  vid_words,
    output logic [CNT_W-1:0]  aux_words
);

    localparam int QMAX = (VID_QUANTUM > AUX_BURST) ? VID_QUANTUM : AUX_BURST;
    localparam int QW   = $clog2(QMAX + 1);

    // qcnt value at which the next read is the last one of the grant
    localparam logic [QW-1:0] VID_LAST = QW'(VID_QUANTUM - 1);
    localparam logic [QW-1:0] AUX_LAST = QW'(AUX_BURST - 1);

    state_t         state;
    logic [QW-1:0]  qcnt;
    grant_t         last_grant;
    logic           aux_urgent;

    assign aux_urgent = (int'(aux_count) >= AUX_HI);

    // Strobes come straight off the registered state so an empty or afull
    // seen this cycle suppresses the read in the same cycle.
    assign vid_rd_en = (state == ST_VID) && !vid_empty && !out_afull && enable;
    assign aux_rd_en = (state == ST_AUX) && !aux_empty && !out_afull && enable;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk125 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            qcnt       <= '0;
            last_grant <= GR_AUX;   // video gets the first grant
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        if (aux_urgent && !aux_empty) begin
                            state      <= ST_AUX;
                            qcnt       <= '0;
                            last_grant <= GR_AUX;
                        end else if (last_grant == GR_AUX && !vid_empty) begin
                            state      <= ST_VID;
                            qcnt       <= '0;
                            last_grant <= GR_VID;
                        end else if (!aux_empty) begin
                            state      <= ST_AUX;
                            qcnt       <= '0;
                            last_grant <= GR_AUX;
                        end else if (!vid_empty) begin
                            state      <= ST_VID;
                            qcnt       <= '0;
                            last_grant <= GR_VID;
                        end
                    end
                end

                ST_VID: begin
                    if (vid_rd_en) begin
                        qcnt <= qcnt + 1'b1;
                        if (qcnt == VID_LAST)
                            state <= ST_IDLE;
                    end else if (vid_empty || !enable) begin
                        state <= ST_IDLE;
                    end
                    // otherwise out_afull: hold position in the quantum
                end

                ST_AUX: begin
                    if (aux_rd_en) begin
                        qcnt <= qcnt + 1'b1;
                        if (qcnt == AUX_LAST)
                            state <= ST_IDLE;
                    end else if (aux_empty || !enable) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- read pipe
    recv_fifo_sched_rd_tag_stage u_rd_tag_stage (
        .clk125    (clk125),
        .sys_rst_n (sys_rst_n),
        .rd_en     (vid_rd_en | aux_rd_en),
        .sel       (aux_rd_en ? TAG_AUX : TAG_VID),
        .vid_dout  (vid_dout),
        .aux_dout  (aux_dout),
        .out_wr_en (out_wr_en),
        .out_data  (out_data)
    );

    // ---------------------------------------------------------------- counters
    always_ff @(posedge clk125 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vid_words <= '0;
            aux_words <= '0;
        end else if (out_wr_en) begin
            if (out_data[OUT_W-1] == TAG_AUX)
                aux_words <= aux_words + 1'b1;
            else
                vid_words <= vid_words + 1'b1;
        end
    end

endmodule

// File: tb/tb_recv_fifo_sched.sv
// ----------------------------------------------------------------------------
// tb_recv_fifo_sched
//   Scoreboard bench for recv_fifo_sched. FIFOs are modelled as queues; a
//   grant-level reference model turns queued FIFO contents into the expected
//   downstream word order, and a monitor pops/compares on every out_wr_en.
// ----------------------------------------------------------------------------
module tb_recv_fifo_sched;

    localparam int VQ  = 16;
    localparam int AB  = 4;
    localparam int AHI = 48;

    logic        clk125 = 1'b0;
    logic        sys_rst_n;
    logic        enable;
    logic        vid_empty;
    logic [28:0] vid_dout;
    logic        vid_rd_en;
    logic        aux_empty;
    logic [23:0] aux_dout;
    logic [6:0]  aux_count;
    logic        aux_rd_en;
    logic        out_afull;
    logic        out_wr_en;
    logic [29:0] out_data;
    logic [15:0] vid_words;
    logic [15:0] aux_words;

    recv_fifo_sched dut (
        .clk125    (clk125),
        .sys_rst_n (sys_rst_n),
        .enable    (enable),
        .vid_empty (vid_empty),
        .vid_dout  (vid_dout),
        .vid_rd_en (vid_rd_en),
        .aux_empty (aux_empty),
        .aux_dout  (aux_dout),
        .aux_count (aux_count),
        .aux_rd_en (aux_rd_en),
        .out_afull (out_afull),
        .out_wr_en (out_wr_en),
        .out_data  (out_data),
        .vid_words (vid_words),
        .aux_words (aux_words)
    );

    always #4 clk125 = ~clk125;

    int checks = 0;
    int errors = 0;

    logic [29:0] exp_q[$];          // scoreboard
    logic [28:0] vq[$];             // video FIFO contents
    logic [23:0] aq[$];             // aux FIFO contents
    logic [28:0] mv[$];             // model's view of words not yet granted
    logic [23:0] ma[$];
    bit          m_last_aux = 1'b1;

    int cyc = 0, rd_cnt = 0, wr_cnt = 0, first_rd = -1, first_wr = -1, last_rd = -1;
    bit first_rd_aux = 1'b0;
    bit rnd_afull = 1'b0;
    int tot_v = 0, tot_a = 0;

    logic [15:0] exp_vw = '0, exp_aw = '0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endfunction

    // One clock: observe strobes mid-cycle, then advance the FIFO models just
    // after the edge so read data appears one cycle after the strobe.
    task automatic tick();
        bit vr, ar;
        @(negedge clk125);
        cyc++;
        vr = vid_rd_en;
        ar = aux_rd_en;
        if (vr || ar) begin
            rd_cnt++;
            last_rd = cyc;
            if (first_rd < 0) begin
                first_rd     = cyc;
                first_rd_aux = ar;
            end
        end
        if (out_wr_en) begin
            wr_cnt++;
            if (first_wr < 0) first_wr = cyc;
        end
        @(posedge clk125);
        #1;
        if (vr && vq.size() > 0) vid_dout = vq.pop_front();
        if (ar && aq.size() > 0) aux_dout = aq.pop_front();
        vid_empty = (vq.size() == 0);
        aux_empty = (aq.size() == 0);
        aux_count = 7'(aq.size());
        if (rnd_afull) out_afull = ($urandom_range(0, 3) == 0);
    endtask

    task automatic load(int nv, int na);
        logic [28:0] w;
        logic [23:0] a;
        for (int i = 0; i < nv; i++) begin
            w = 29'($urandom);
            vq.push_back(w);
            mv.push_back(w);
        end
        for (int i = 0; i < na; i++) begin
            a = 24'($urandom);
            aq.push_back(a);
            ma.push_back(a);
        end
        tot_v += nv;
        tot_a += na;
        vid_empty = (vq.size() == 0);
        aux_empty = (aq.size() == 0);
        aux_count = 7'(aq.size());
        rd_cnt = 0; wr_cnt = 0; first_rd = -1; first_wr = -1; last_rd = -1;
    endtask

    // Grant-level reference: pick a class by the arbitration rules using the
    // words still waiting, take up to one quantum/burst, repeat.
    task automatic model_drain();
        int n;
        bit take_aux;
        while (mv.size() > 0 || ma.size() > 0) begin
            if (ma.size() >= AHI)                 take_aux = 1'b1;
            else if (m_last_aux && mv.size() > 0) take_aux = 1'b0;
            else if (ma.size() > 0)               take_aux = 1'b1;
            else                                  take_aux = 1'b0;
            if (take_aux) begin
                n = (ma.size() < AB) ? ma.size() : AB;
                repeat (n) exp_q.push_back({1'b1, 5'b0, ma.pop_front()});
                m_last_aux = 1'b1;
            end else begin
                n = (mv.size() < VQ) ? mv.size() : VQ;
                repeat (n) exp_q.push_back({1'b0, mv.pop_front()});
                m_last_aux = 1'b0;
            end
        end
    endtask

    task automatic wait_drain(string nm, int budget);
        int n = 0;
        while ((exp_q.size() > 0 || vq.size() > 0 || aq.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        chk({"drain_", nm}, 32'(exp_q.size() + vq.size() + aq.size()), 32'd0);
        tick();
        tick();
    endtask

    task automatic wait_reads(string nm, int k);
        int n = 0;
        while (rd_cnt < k && n < 200) begin
            tick();
            n++;
        end
        chk(nm, 32'(rd_cnt >= k), 32'd1);
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge clk125) begin
        logic [29:0] e;
        if (!sys_rst_n) begin
            exp_q.delete();
            exp_vw = '0;
            exp_aw = '0;
        end else begin
            if (vid_rd_en || aux_rd_en)
                chk("rd_legal", 32'({vid_rd_en & aux_rd_en, vid_rd_en & vid_empty,
                                     aux_rd_en & aux_empty, out_afull, ~enable}), 32'd0);
            if (out_wr_en) begin
                chk("vid_words", 32'(vid_words), 32'(exp_vw));
                chk("aux_words", 32'(aux_words), 32'(exp_aw));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got data 0x%0h, expected no write", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e));
                    if (e[29]) exp_aw = exp_aw + 16'd1;
                    else       exp_vw = exp_vw + 16'd1;
                end
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        int nwrap;
        sys_rst_n = 1'b0;
        enable    = 1'b1;
        vid_empty = 1'b1;
        aux_empty = 1'b1;
        vid_dout  = '0;
        aux_dout  = '0;
        aux_count = '0;
        out_afull = 1'b0;
        repeat (3) tick();
        chk("reset_outs", 32'({vid_rd_en, aux_rd_en, out_wr_en, |out_data,
                               |vid_words, |aux_words}), 32'd0);
        sys_rst_n = 1'b1;
        tick();

        // Reset mid-burst: outputs drop at once, in-flight words vanish.
        load(40, 0);
        model_drain();
        wait_reads("reset_burst_reads", 5);
        sys_rst_n = 1'b0;
        #1;
        chk("reset_midburst_outs", 32'({vid_rd_en, aux_rd_en, out_wr_en, |out_data,
                                        |vid_words, |aux_words}), 32'd0);
        vq.delete(); aq.delete(); mv.delete(); ma.delete();
        m_last_aux = 1'b1;
        tot_v = 0; tot_a = 0;
        vid_empty = 1'b1; aux_empty = 1'b1; aux_count = '0;
        repeat (3) tick();
        sys_rst_n = 1'b1;
        wr_cnt = 0;
        repeat (4) tick();
        chk("post_reset_quiet", 32'(wr_cnt), 32'd0);

        // Both busy: V16 A4 V16 A4, video first after reset, latency 2.
        load(32, 8);
        model_drain();
        wait_drain("both_busy", 400);
        chk("first_grant_vid", 32'(first_rd_aux), 32'd0);
        chk("latency", 32'(first_wr - first_rd), 32'd2);

        // Urgent aux in IDLE beats last_grant=AUX round-robin.
        load(20, 50);
        model_drain();
        wait_drain("urgent_idle", 400);
        chk("urgent_first_aux", 32'(first_rd_aux), 32'd1);

        // Urgent aux arriving mid-quantum waits for the quantum to finish.
        load(32, 0);
        for (int i = 0; i < VQ; i++) exp_q.push_back({1'b0, mv.pop_front()});
        m_last_aux = 1'b0;
        wait_reads("urgent_mid_reads", 3);
        load(0, 50);
        model_drain();
        wait_drain("urgent_mid", 600);

        // Video only: 16,16,8 with one idle cycle between bursts.
        load(40, 0);
        model_drain();
        wait_drain("video_only", 400);
        chk("video_span", 32'(last_rd - first_rd + 1), 32'd42);
        chk("vid_words_total", 32'(vid_words), 32'(tot_v & 32'hFFFF));

        // Backpressure for 5 cycles mid-quantum.
        load(32, 0);
        model_drain();
        wait_reads("bp_reads", 5);
        out_afull = 1'b1;
        rd_cnt = 0;
        wr_cnt = 0;
        repeat (5) tick();
        chk("bp_no_reads", 32'(rd_cnt), 32'd0);
        chk("bp_inflight_writes", 32'(wr_cnt), 32'd2);
        out_afull = 1'b0;
        wait_drain("backpressure", 400);

        // enable drop mid-AUX: in-flight words land, no further reads.
        load(0, 8);
        repeat (2) exp_q.push_back({1'b1, 5'b0, ma.pop_front()});
        wait_reads("en_reads", 2);
        enable = 1'b0;
        rd_cnt = 0;
        wr_cnt = 0;
        repeat (10) tick();
        chk("en_off_no_reads", 32'(rd_cnt), 32'd0);
        chk("en_off_inflight", 32'(wr_cnt), 32'd2);
        enable = 1'b1;
        m_last_aux = 1'b1;
        model_drain();
        wait_drain("enable_resume", 200);

        // Randomized mixes with random backpressure.
        rnd_afull = 1'b1;
        for (int r = 0; r < 6; r++) begin
            load($urandom_range(0, 60), $urandom_range(0, 70));
            model_drain();
            wait_drain("random", 4000);
        end
        rnd_afull = 1'b0;
        out_afull = 1'b0;
        tick();
        chk("aux_words_total", 32'(aux_words), 32'(tot_a & 32'hFFFF));

        // Counter wrap: push video traffic past 16'hFFFF.
        nwrap = 65536 - (tot_v % 65536) + 3;
        load(nwrap, 0);
        model_drain();
        wait_drain("wrap", 80000);
        chk("vid_words_wrap", 32'(vid_words), 32'(tot_v & 32'hFFFF));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
